// File: rtl/sum_accumulator.sv
// Block accumulator: sums a programmable number of unsigned samples and
// presents the total on a valid/ready output handshake.
module sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CNT_W-1:0]        len,
  input  logic                    clear,
  output logic [DATA_W+CNT_W-1:0] out_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int SUM_W = DATA_W + CNT_W;
  localparam int CW    = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_r;
  logic [SUM_W-1:0]  acc_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     target_r;

  logic [CW-1:0]     first_target_s;
  logic [SUM_W-1:0]  sample_ext_s;
  logic [SUM_W-1:0]  next_acc_s;
  logic [CW-1:0]     next_cnt_s;

  // len of zero stands for a full 2^CNT_W block, hence the extra counter bit
  assign first_target_s = (len == {CNT_W{1'b0}}) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
  assign sample_ext_s   = {{CNT_W{1'b0}}, in_data};
  assign next_acc_s     = acc_r + sample_ext_s;
  assign next_cnt_s     = cnt_r + {{CNT_W{1'b0}}, 1'b1};

  // Block FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      acc_r     <= {SUM_W{1'b0}};
      cnt_r     <= {CW{1'b0}};
      target_r  <= {CW{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= {SUM_W{1'b0}};
      busy      <= 1'b0;
    end else if (clear) begin
      state_r   <= IDLE;
      acc_r     <= {SUM_W{1'b0}};
      cnt_r     <= {CW{1'b0}};
      target_r  <= {CW{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= {SUM_W{1'b0}};
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            target_r <= first_target_s;
            acc_r    <= sample_ext_s;
            cnt_r    <= {{CNT_W{1'b0}}, 1'b1};
            busy     <= 1'b1;
            if (first_target_s == {{CNT_W{1'b0}}, 1'b1}) begin
              state_r   <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= sample_ext_s;
            end else begin
              state_r   <= ACCUM;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_r <= next_acc_s;
            cnt_r <= next_cnt_s;
            if (next_cnt_s == target_r) begin
              state_r   <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= next_acc_s;
            end else begin
              state_r   <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            acc_r     <= {SUM_W{1'b0}};
            cnt_r     <= {CW{1'b0}};
            target_r  <= {CW{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= {SUM_W{1'b0}};
            busy      <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          acc_r     <= {SUM_W{1'b0}};
          cnt_r     <= {CW{1'b0}};
          target_r  <= {CW{1'b0}};
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_sum   <= {SUM_W{1'b0}};
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed scenarios plus random traffic, checked
// against a queue-based model of block summation.
module tb_sum_accumulator;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CNT_W-1:0]  len;
  logic              clear;
  logic [DATA_W+CNT_W-1:0] out_sum;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  sum_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .len(len), .clear(clear), .out_sum(out_sum),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: samples of the open block, its target, and a pending result
  int q[$];
  int m_target = 0;
  bit m_done   = 1'b0;
  int m_result = 0;

  function automatic void model_reset();
    q.delete();
    m_target = 0;
    m_done   = 1'b0;
    m_result = 0;
  endfunction

  function automatic void model_edge();
    if (clear) begin
      model_reset();
    end else if (m_done) begin
      if (out_ready) begin
        m_done   = 1'b0;
        m_result = 0;
      end
    end else if (in_valid) begin
      if (q.size() == 0) m_target = (len == 4'd0) ? 16 : int'(len);
      q.push_back(int'(in_data));
      if (q.size() == m_target) begin
        m_result = 0;
        foreach (q[i]) m_result += q[i];
        m_done = 1'b1;
        q.delete();
      end
    end
  endfunction

  task automatic check(input string tag);
    logic        exp_ready, exp_valid, exp_busy;
    logic [11:0] exp_sum;
    exp_ready = !m_done;
    exp_valid = m_done;
    exp_busy  = m_done || (q.size() > 0);
    exp_sum   = m_done ? 12'(m_result) : 12'd0;
    total++;
    assert (in_ready === exp_ready) else begin
      bad++; $error("FAIL %s in_ready got=%0b want=%0b", tag, in_ready, exp_ready);
    end
    total++;
    assert (out_valid === exp_valid) else begin
      bad++; $error("FAIL %s out_valid got=%0b want=%0b", tag, out_valid, exp_valid);
    end
    total++;
    assert (out_sum === exp_sum) else begin
      bad++; $error("FAIL %s out_sum got=%0d want=%0d", tag, out_sum, exp_sum);
    end
    total++;
    assert (busy === exp_busy) else begin
      bad++; $error("FAIL %s busy got=%0b want=%0b", tag, busy, exp_busy);
    end
  endtask

  task automatic expect_sum(input string tag, input int want);
    total++;
    assert (out_valid === 1'b1 && out_sum === 12'(want)) else begin
      bad++; $error("FAIL %s out_valid=%0b out_sum got=%0d want=%0d", tag, out_valid, out_sum, want);
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check(tag);
  endtask

  task automatic send(input int d, input int l, input string tag);
    in_valid = 1'b1;
    in_data  = 8'(d);
    len      = 4'(l);
    cyc(tag);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_data = 8'd0; in_valid = 1'b0; len = 4'd0;
    clear = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1 model_reset();
    check("reset_async");
    @(negedge clk);
    check("reset_held");
    #2 rst = 1'b0;
    @(negedge clk);
    check("after_reset");

    // len=3, 10+20+30, out_ready high throughout
    out_ready = 1'b1;
    send(10, 3, "s35_a"); send(20, 3, "s35_b"); send(30, 3, "s35_c");
    expect_sum("s35_sum", 60);
    cyc("s35_xfer");

    // len=0 means 16 samples of 255
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(255, 0, "s36_acc");
    expect_sum("s36_sum", 4080);
    out_ready = 1'b1;
    cyc("s36_xfer");

    // len=1 with back-pressure; in_valid kept high must not be accepted
    out_ready = 1'b0;
    send(7, 1, "s37_acc");
    in_valid = 1'b1; in_data = 8'd99;
    for (int i = 0; i < 5; i++) cyc("s37_hold");
    expect_sum("s37_sum", 7);
    out_ready = 1'b1;
    cyc("s37_xfer");
    in_valid = 1'b0;

    // clear mid-block drops the presented sample too
    send(4, 4, "s38_a"); send(6, 4, "s38_b");
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd50;
    cyc("s38_clear");
    clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0;
    send(1, 2, "s38_c"); send(2, 2, "s38_d");
    expect_sum("s38_sum", 3);
    out_ready = 1'b1;
    cyc("s38_xfer");

    // asynchronous reset pulse between edges after 3 samples
    send(3, 4, "s39_a"); send(3, 4, "s39_b"); send(3, 4, "s39_c");
    #2 rst = 1'b1;
    #1 model_reset();
    check("s39_rst_now");
    #1 rst = 1'b0;
    @(negedge clk);
    check("s39_released");
    out_ready = 1'b0;
    send(5, 2, "s39_d"); send(5, 2, "s39_e");
    expect_sum("s39_sum", 10);
    out_ready = 1'b1;
    cyc("s39_xfer");

    // gaps and a mid-block len change
    send(11, 3, "s40_a");
    len = 4'd1; cyc("s40_gap1");
    send(22, 1, "s40_b");
    cyc("s40_gap2");
    out_ready = 1'b0;
    send(33, 1, "s40_c");
    expect_sum("s40_sum", 66);
    out_ready = 1'b1;
    cyc("s40_xfer");

    // random traffic with occasional clears
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      len       = 4'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      clear     = ($urandom_range(0, 40) == 0);
      cyc("rand");
    end
    clear = 1'b0; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
